viterbi_frame_scheduler: RTL

Parametrised multi-frame launcher that sits in front of `viterbi_core` and replaces single-shot, hand-pulsed frame starts. It accepts frame descriptors through a valid/ready port into a DEPTH-entry FIFO and presents each frame's configuration to the core. It then pulses `frame_start`, waits for `frame_done` under a watchdog, and enforces a minimum inter-frame gap. On timeout it aborts the core via its synchronous reset and continues with the next frame.

---
 rtl/viterbi_frame_scheduler.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/viterbi_frame_scheduler.sv
// Multi-frame launcher for viterbi_core: queues frame descriptors, launches them one at a time,
// aborts a hung frame through the core's synchronous reset and enforces an inter-frame gap.
module viterbi_frame_scheduler #(
    parameter int SRC_ADDR_W     = 12,
    parameter int DST_ADDR_W     = 12,
    parameter int DEPTH          = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int GAP_CYCLES     = 2,
    parameter int ABORT_CYCLES   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_an_i,
    input  logic                    enable_i,
    input  logic                    flush_i,
    input  logic                    clear_err_i,
    input  logic                    desc_valid_i,
    output logic                    desc_ready_o,
    input  logic [SRC_ADDR_W-1:0]   desc_src_addr_i,
    input  logic [DST_ADDR_W-1:0]   desc_dst_addr_i,
    input  logic [10:0]             desc_infobit_len_i,
    input  logic [11:0]             desc_decoding_len_i,
    input  logic                    desc_tail_biting_i,
    input  logic [1:0]              desc_register_num_i,
    input  logic [2:0]              desc_valid_polys_i,
    output logic                    frame_start_o,
    output logic [SRC_ADDR_W-1:0]   src_start_addr_o,
    output logic [DST_ADDR_W-1:0]   dst_start_addr_o,
    output logic [10:0]             infobit_length_o,
    output logic [11:0]             decoding_length_o,
    output logic                    tail_biting_en_o,
    output logic [1:0]              register_num_o,
    output logic [2:0]              valid_polynomials_o,
    output logic                    core_rst_sync_o,
    input  logic                    frame_done_i,
    input  logic                    busy_i,
    output logic [$clog2(DEPTH):0]  fifo_level_o,
    output logic [CNT_W-1:0]        frames_done_o,
    output logic [CNT_W-1:0]        frames_aborted_o,
    output logic                    timeout_err_o,
    output logic                    desc_err_o,
    output logic                    idle_o
);
    localparam int AW     = $clog2(DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int DESC_W = SRC_ADDR_W + DST_ADDR_W + 29;
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HOLD_N = (ABORT_CYCLES > GAP_CYCLES) ? ABORT_CYCLES : GAP_CYCLES;
    localparam int HOLD_W = $clog2(HOLD_N + 1);

    localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(TIMEOUT_CYCLES);
    localparam logic [HOLD_W-1:0] ABORT_LAST = HOLD_W'(ABORT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] GAP_LAST   = HOLD_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W-1:0]  DEPTH_LVL  = PTR_W'(DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_ABORT  = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_d, level_q;
    logic [DESC_W-1:0] mem_q [DEPTH];
    logic [DESC_W-1:0] wr_word_s, rd_word_s;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              empty_s, illegal_s, accept_s, push_s, pop_s, done_s, abort_s;
    logic              terr_d, derr_d;
    logic              ready_q, start_q, core_rst_q, idle_q, terr_q, derr_q;
    logic [CNT_W-1:0]  done_cnt_q, abort_cnt_q;
    logic [SRC_ADDR_W-1:0] src_q;
    logic [DST_ADDR_W-1:0] dst_q;
    logic [10:0]       info_q;
    logic [11:0]       dec_q;
    logic              tb_q;
    logic [1:0]        rn_q;
    logic [2:0]        vp_q;
    logic              busy_unused_s;

    // busy_i is purely informational; the watchdog runs regardless of it.
    assign busy_unused_s = busy_i;

    assign empty_s   = (wr_ptr_q == rd_ptr_q);
    assign illegal_s = (desc_infobit_len_i == 11'd0) ||
                       ({1'b0, desc_infobit_len_i} > desc_decoding_len_i);
    assign accept_s  = desc_valid_i & ready_q;
    assign push_s    = accept_s & ~illegal_s & ~flush_i;
    assign wr_word_s = {desc_src_addr_i, desc_dst_addr_i, desc_infobit_len_i, desc_decoding_len_i,
                        desc_tail_biting_i, desc_register_num_i, desc_valid_polys_i};
    assign rd_word_s = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state, watchdog and hold-counter logic.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        hold_d  = hold_q;
        pop_s   = 1'b0;
        done_s  = 1'b0;
        abort_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && !empty_s && !flush_i) begin
                    pop_s   = 1'b1;
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                wd_d    = WD_W'(1);
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Completion on the final watchdog cycle takes precedence over the abort.
                if (frame_done_i) begin
                    done_s  = 1'b1;
                    hold_d  = {HOLD_W{1'b0}};
                    state_d = ST_GAP;
                end else if (wd_q == WD_LIMIT) begin
                    abort_s = 1'b1;
                    hold_d  = {HOLD_W{1'b0}};
                    state_d = ST_ABORT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_ABORT: begin
                if (hold_q == ABORT_LAST) begin
                    hold_d  = {HOLD_W{1'b0}};
                    state_d = ST_GAP;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_GAP: begin
                if (hold_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer update; flush discards everything including a same-cycle push.
    always_comb begin
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
        end else begin
            wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
            rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        end
        level_d = wr_ptr_d - rd_ptr_d;
    end

    // Sticky error flags; a set in the same cycle beats the clear.
    always_comb begin
        if (abort_s) begin
            terr_d = 1'b1;
        end else if (clear_err_i) begin
            terr_d = 1'b0;
        end else begin
            terr_d = terr_q;
        end
        if (accept_s && illegal_s) begin
            derr_d = 1'b1;
        end else if (clear_err_i) begin
            derr_d = 1'b0;
        end else begin
            derr_d = derr_q;
        end
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_an_i) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            level_q     <= {PTR_W{1'b0}};
            wd_q        <= {WD_W{1'b0}};
            hold_q      <= {HOLD_W{1'b0}};
            ready_q     <= 1'b0;
            start_q     <= 1'b0;
            core_rst_q  <= 1'b0;
            idle_q      <= 1'b0;
            terr_q      <= 1'b0;
            derr_q      <= 1'b0;
            done_cnt_q  <= {CNT_W{1'b0}};
            abort_cnt_q <= {CNT_W{1'b0}};
            src_q       <= {SRC_ADDR_W{1'b0}};
            dst_q       <= {DST_ADDR_W{1'b0}};
            info_q      <= 11'd0;
            dec_q       <= 12'd0;
            tb_q        <= 1'b0;
            rn_q        <= 2'd0;
            vp_q        <= 3'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            wd_q       <= wd_d;
            hold_q     <= hold_d;
            ready_q    <= (level_d != DEPTH_LVL);
            start_q    <= (state_d == ST_LAUNCH);
            core_rst_q <= (state_d == ST_ABORT);
            idle_q     <= (state_d == ST_IDLE) && (level_d == {PTR_W{1'b0}});
            terr_q     <= terr_d;
            derr_q     <= derr_d;
            if (done_s) begin
                done_cnt_q <= done_cnt_q + CNT_W'(1);
            end
            if (abort_s) begin
                abort_cnt_q <= abort_cnt_q + CNT_W'(1);
            end
            if (pop_s) begin
                {src_q, dst_q, info_q, dec_q, tb_q, rn_q, vp_q} <= rd_word_s;
            end
        end
    end

    // Descriptor storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_word_s;
        end
    end

    assign desc_ready_o        = ready_q;
    assign fifo_level_o        = level_q;
    assign frame_start_o       = start_q;
    assign core_rst_sync_o     = core_rst_q;
    assign idle_o              = idle_q;
    assign timeout_err_o       = terr_q;
    assign desc_err_o          = derr_q;
    assign frames_done_o       = done_cnt_q;
    assign frames_aborted_o    = abort_cnt_q;
    assign src_start_addr_o    = src_q;
    assign dst_start_addr_o    = dst_q;
    assign infobit_length_o    = info_q;
    assign decoding_length_o   = dec_q;
    assign tail_biting_en_o    = tb_q;
    assign register_num_o      = rn_q;
    assign valid_polynomials_o = vp_q;

endmodule
